// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver, 16x oversampling, show-ahead byte FIFO.
// Define UART_RX_PARITY_EN for an even parity bit and the par_err output.
module uart_rx #(
    parameter int unsigned cnt_max = 26,
    parameter int unsigned fifo_aw = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    input  logic       rd_en,
    input  logic       err_clr,
    output logic [7:0] dout,
    output logic       dout_en,
    output logic       frame_err,
`ifdef UART_RX_PARITY_EN
    output logic       par_err,
`endif
    output logic       of_err
);

    localparam int unsigned DEPTH = 1 << fifo_aw;
    localparam logic [8:0] TICK_MAX = 9'(cnt_max);
    localparam logic [fifo_aw:0] PTR_ONE = {{fifo_aw{1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP,
        S_BRK
    } state_e;

    logic             rxd_meta_q, rxs_q;
    logic [8:0]       tick_cnt_q, tick_cnt_d;
    logic             tick;
    state_e           state_q, state_d;
    logic [3:0]       smp_cnt_q, smp_cnt_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       shreg_q, shreg_d;
    logic             push_q, push_d;
    logic             frame_set, par_set;
    logic             frame_err_q, frame_err_d;
    logic             of_err_q, of_err_d;
    logic             par_err_q, par_err_d;
    logic [fifo_aw:0] head_q, head_d, tail_q, tail_d;
    logic [7:0]       mem_q [DEPTH];
    logic             empty, full, pop, wr, ovf;

    // Two-flop synchroniser; idles high so reset never looks like a start bit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rxd_meta_q <= 1'b1;
            rxs_q      <= 1'b1;
        end else begin
            rxd_meta_q <= rxd;
            rxs_q      <= rxd_meta_q;
        end
    end

    assign tick       = (tick_cnt_q == TICK_MAX);
    assign tick_cnt_d = tick ? 9'd0 : tick_cnt_q + 9'd1;

    // Receive FSM next state; everything moves only on oversampling ticks.
    always_comb begin
        state_d   = state_q;
        smp_cnt_d = smp_cnt_q;
        bit_cnt_d = bit_cnt_q;
        shreg_d   = shreg_q;
        push_d    = 1'b0;
        frame_set = 1'b0;
        par_set   = 1'b0;
        if (tick) begin
            unique case (state_q)
                S_IDLE: begin
                    if (!rxs_q) begin
                        state_d   = S_START;
                        smp_cnt_d = 4'd0;
                    end
                end
                S_START: begin
                    if (smp_cnt_q == 4'd7) begin
                        smp_cnt_d = 4'd0;
                        bit_cnt_d = 3'd0;
                        state_d   = rxs_q ? S_IDLE : S_DATA;
                    end else begin
                        smp_cnt_d = smp_cnt_q + 4'd1;
                    end
                end
                S_DATA: begin
                    smp_cnt_d = smp_cnt_q + 4'd1;
                    if (smp_cnt_q == 4'd15) begin
                        shreg_d   = {rxs_q, shreg_q[7:1]};
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state_d = S_PARITY;
`else
                            state_d = S_STOP;
`endif
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    smp_cnt_d = smp_cnt_q + 4'd1;
                    if (smp_cnt_q == 4'd15) begin
                        par_set = (rxs_q != ^shreg_q);
                        state_d = S_STOP;
                    end
                end
`endif
                S_STOP: begin
                    smp_cnt_d = smp_cnt_q + 4'd1;
                    if (smp_cnt_q == 4'd15) begin
                        if (rxs_q) begin
                            push_d  = 1'b1;
                            state_d = S_IDLE;
                        end else begin
                            frame_set = 1'b1;
                            state_d   = S_BRK;
                        end
                    end
                end
                S_BRK: begin
                    if (rxs_q) state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // FIFO pointer arithmetic, overrun detection and sticky error flags.
    always_comb begin
        empty = (head_q == tail_q);
        full  = (head_q[fifo_aw] != tail_q[fifo_aw]) &&
                (head_q[fifo_aw-1:0] == tail_q[fifo_aw-1:0]);
        pop   = rd_en && !empty;
        wr    = push_q && (!full || pop);
        ovf   = push_q && full && !pop;
        head_d = pop ? head_q + PTR_ONE : head_q;
        tail_d = wr ? tail_q + PTR_ONE : tail_q;
        frame_err_d = err_clr ? 1'b0 : (frame_err_q | frame_set);
        of_err_d    = err_clr ? 1'b0 : (of_err_q | ovf);
        par_err_d   = err_clr ? 1'b0 : (par_err_q | par_set);
    end

    // State, counters, pointers and flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tick_cnt_q  <= 9'd0;
            state_q     <= S_IDLE;
            smp_cnt_q   <= 4'd0;
            bit_cnt_q   <= 3'd0;
            shreg_q     <= 8'd0;
            push_q      <= 1'b0;
            head_q      <= '0;
            tail_q      <= '0;
            frame_err_q <= 1'b0;
            of_err_q    <= 1'b0;
            par_err_q   <= 1'b0;
        end else begin
            tick_cnt_q  <= tick_cnt_d;
            state_q     <= state_d;
            smp_cnt_q   <= smp_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shreg_q     <= shreg_d;
            push_q      <= push_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            frame_err_q <= frame_err_d;
            of_err_q    <= of_err_d;
            par_err_q   <= par_err_d;
        end
    end

    // Storage; shreg_q is stable for many ticks after the stop bit.
    always_ff @(posedge clk) begin
        if (wr) mem_q[tail_q[fifo_aw-1:0]] <= shreg_q;
    end

    assign dout      = empty ? 8'h00 : mem_q[head_q[fifo_aw-1:0]];
    assign dout_en   = !empty;
    assign frame_err = frame_err_q;
    assign of_err    = of_err_q;
`ifdef UART_RX_PARITY_EN
    assign par_err   = par_err_q;
`else
    logic unused_par;
    assign unused_par = par_err_q;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: randomized frames against a frame-level receiver model.
// Model times samples from tick numbers; FIFO is a queue.
module tb_uart_rx;

    localparam int CNT = 3;
    localparam int BIT_CLKS = 16 * (CNT + 1);
`ifdef UART_RX_PARITY_EN
    localparam int NB = 9;
`else
    localparam int NB = 8;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic rxd = 1'b1;
    logic rd_en = 1'b0;
    logic err_clr = 1'b0;
    logic [7:0] dout;
    logic dout_en, frame_err, of_err;
`ifdef UART_RX_PARITY_EN
    logic par_err;
`endif

    int checks = 0;
    int failures = 0;

    uart_rx #(.cnt_max(CNT), .fifo_aw(4)) dut (
        .clk(clk),
        .rst(rst),
        .rxd(rxd),
        .rd_en(rd_en),
        .err_clr(err_clr),
        .dout(dout),
        .dout_en(dout_en),
        .frame_err(frame_err),
`ifdef UART_RX_PARITY_EN
        .par_err(par_err),
`endif
        .of_err(of_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [7:0] q[$];
    bit m_ferr = 0, m_oerr = 0, m_perr = 0;
    bit push_pend = 0;
    logic [7:0] push_byte = 8'h00;
    int cyc = 0, tick_n = 0, t0 = 0;
    bit h1 = 1, h2 = 1, busy = 0, brk = 0;
    logic [8:0] m_bits = '0;

    always @(posedge clk or negedge rst) begin
        bit rs, fset, pset, oset, pp;
        int rel, k;
        if (!rst) begin
            q.delete();
            m_ferr = 0; m_oerr = 0; m_perr = 0;
            push_pend = 0; cyc = 0; tick_n = 0;
            h1 = 1; h2 = 1; busy = 0; brk = 0;
        end else begin
            rs = h2; h2 = h1; h1 = rxd;
            fset = 0; pset = 0; oset = 0;
            pp = rd_en && (q.size() != 0);
            if (push_pend && q.size() == 16 && !pp) oset = 1;
            else begin
                if (pp) void'(q.pop_front());
                if (push_pend) q.push_back(push_byte);
            end
            push_pend = 0;
            if ((cyc % (CNT + 1)) == CNT) begin
                tick_n++;
                if (busy) begin
                    rel = tick_n - t0;
                    if (rel == 8) begin
                        if (rs) busy = 0;
                    end else if (rel > 8 && (rel - 8) % 16 == 0) begin
                        k = (rel - 8) / 16 - 1;
                        if (k < NB) begin
                            m_bits[k] = rs;
                            if (k == 8) pset = (rs != ^m_bits[7:0]);
                        end else begin
                            busy = 0;
                            if (rs) begin
                                push_pend = 1;
                                push_byte = m_bits[7:0];
                            end else begin
                                fset = 1;
                                brk = 1;
                            end
                        end
                    end
                end else if (brk) begin
                    if (rs) brk = 0;
                end else if (!rs) begin
                    busy = 1;
                    t0 = tick_n;
                end
            end
            cyc++;
            m_ferr = err_clr ? 0 : (m_ferr | fset);
            m_oerr = err_clr ? 0 : (m_oerr | oset);
            m_perr = err_clr ? 0 : (m_perr | pset);
        end
    end

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        if (rst) begin
            chk("dout_en", dout_en, q.size() != 0);
            if (q.size() != 0) chk("dout", dout, q[0]);
            chk("frame_err", frame_err, m_ferr);
            chk("of_err", of_err, m_oerr);
`ifdef UART_RX_PARITY_EN
            chk("par_err", par_err, m_perr);
`endif
        end
    end

    // ---------------- stimulus ----------------
    task automatic hold(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] b, input bit stop_v);
        rxd = 1'b0; hold(BIT_CLKS);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i]; hold(BIT_CLKS);
        end
`ifdef UART_RX_PARITY_EN
        rxd = ^b; hold(BIT_CLKS);
`endif
        rxd = stop_v; hold(BIT_CLKS);
        rxd = 1'b1;
    endtask

    task automatic read_exp(input string nm, input logic [7:0] e);
        chk({nm, "_en"}, dout_en, 1);
        chk(nm, dout, e);
        rd_en = 1'b1; hold(1);
        rd_en = 1'b0; hold(1);
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1; hold(1);
        err_clr = 1'b0; hold(1);
    endtask

    bit rnd_done = 0;
    int rdp = 0;

    initial begin
        hold(3);
        chk("rst_dout", dout, 8'h00);
        chk("rst_dout_en", dout_en, 0);
        chk("rst_frame_err", frame_err, 0);
        chk("rst_of_err", of_err, 0);
        rst = 1'b1;
        hold(10);

        // single frame
        send(8'h55, 1);
        chk("t1_en", dout_en, 1);
        chk("t1_dout", dout, 8'h55);
        chk("t1_ferr", frame_err, 0);
        read_exp("t1_rd", 8'h55);
        chk("t1_empty", dout_en, 0);

        // start-bit glitch
        rxd = 1'b0; hold(16);
        rxd = 1'b1; hold(200);
        chk("t2_en", dout_en, 0);
        chk("t2_ferr", frame_err, 0);
        chk("t2_oerr", of_err, 0);

        // framing error and break
        send(8'hA3, 0);
        rxd = 1'b0; hold(200);
        rxd = 1'b1; hold(100);
        chk("t3_ferr", frame_err, 1);
        chk("t3_en", dout_en, 0);
        send(8'h0F, 1); hold(10);
        chk("t3_dout", dout, 8'h0F);
        pulse_clr();
        chk("t3_clr", frame_err, 0);
        read_exp("t3_rd", 8'h0F);

        // overrun
        for (int i = 0; i < 17; i++) begin
            send(8'(i), 1); hold(8);
        end
        hold(10);
        chk("t4_oerr", of_err, 1);
        for (int i = 0; i < 16; i++) read_exp("t4_rd", 8'(i));
        chk("t4_empty", dout_en, 0);
        pulse_clr();
        chk("t4_clr", of_err, 0);

        // push and pop together while full
        for (int i = 0; i < 16; i++) begin
            send(8'(i), 1); hold(8);
        end
        fork
            send(8'h10, 1);
            begin
                int n = 0;
                while (!push_pend && n < 2000) begin
                    hold(1); n++;
                end
                checks++;
                if (!push_pend) begin
                    failures++;
                    $display("FAIL t5_push_wait actual=timeout required=push");
                end
                rd_en = 1'b1; hold(1);
                rd_en = 1'b0;
            end
        join
        hold(10);
        chk("t5_oerr", of_err, 0);
        for (int i = 1; i <= 16; i++) read_exp("t5_rd", 8'(i));
        chk("t5_empty", dout_en, 0);

        // reset mid-frame
        rxd = 1'b0; hold(BIT_CLKS);
        rxd = 1'b1; hold(BIT_CLKS);
        rxd = 1'b1; hold(BIT_CLKS);
        rxd = 1'b0; hold(BIT_CLKS / 2);
        rst = 1'b0; hold(3);
        chk("t6_dout", dout, 8'h00);
        chk("t6_en", dout_en, 0);
        chk("t6_ferr", frame_err, 0);
        chk("t6_oerr", of_err, 0);
        rxd = 1'b1; rst = 1'b1; hold(50);
        send(8'h3C, 1); hold(10);
        read_exp("t6_rd", 8'h3C);

        // randomized traffic
        fork
            begin
                for (int f = 0; f < 28; f++) begin
                    int kind;
                    kind = $urandom_range(0, 9);
                    rdp = (f < 20) ? 1 : 300;
                    if (kind == 0) begin
                        send(8'($urandom), 0);
                        rxd = 1'b0; hold($urandom_range(0, 150));
                        rxd = 1'b1;
                    end else if (kind == 1) begin
                        rxd = 1'b0; hold($urandom_range(4, 20));
                        rxd = 1'b1;
                    end else begin
                        send(8'($urandom), 1);
                    end
                    hold($urandom_range(8, 100));
                end
                rnd_done = 1;
            end
            begin
                while (!rnd_done) begin
                    rd_en = ($urandom_range(0, 999) < rdp);
                    err_clr = ($urandom_range(0, 299) == 0);
                    hold(1);
                end
                rd_en = 1'b0;
                err_clr = 1'b0;
            end
        join
        for (int i = 0; i < 20 && dout_en; i++) begin
            rd_en = 1'b1; hold(1);
            rd_en = 1'b0; hold(1);
        end
        hold(5);
        chk("final_empty", dout_en, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
